tcam_sdram_arbiter: RTL and testbench

//  Shares the single SDRAM-controller slave port between the TCAM search engine (port 0, SRCH_*) and the

---
 rtl/tcam_sdram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_tcam_sdram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_sdram_arbiter.sv
// tcam_sdram_arbiter: shares the SDRAM controller slave port between the TCAM search port (0)
// and the rule-setting port (1); tracks outstanding reads so each return beat reaches its issuer.
// Build option: define TCAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module tcam_sdram_arbiter #(
    parameter int unsigned ADDR_WID  = 19,
    parameter int unsigned DATA_WID  = 180,
    parameter int unsigned MAX_PEND  = 8,
    parameter int unsigned PEND_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    // port 0: search engine
    input  logic                  SRCH_READ,
    input  logic                  SRCH_WRITE,
    input  logic [ADDR_WID-1:0]   SRCH_ADDRESS,
    input  logic [DATA_WID-1:0]   SRCH_WRITEDATA,
    output logic                  SRCH_WAITREQUEST,
    output logic [DATA_WID-1:0]   SRCH_READDATA,
    output logic                  SRCH_READDATAVALID,
    // port 1: rule-setting engine
    input  logic                  SET_READ,
    input  logic                  SET_WRITE,
    input  logic [ADDR_WID-1:0]   SET_ADDRESS,
    input  logic [DATA_WID-1:0]   SET_WRITEDATA,
    output logic                  SET_WAITREQUEST,
    output logic [DATA_WID-1:0]   SET_READDATA,
    output logic                  SET_READDATAVALID,
    // downstream SDRAM controller slave
    output logic                  M_READ,
    output logic                  M_WRITE,
    output logic [ADDR_WID-1:0]   M_ADDRESS,
    output logic [DATA_WID-1:0]   M_WRITEDATA,
    input  logic                  M_WAITREQUEST,
    input  logic [DATA_WID-1:0]   M_READDATA,
    input  logic                  M_READDATAVALID,
    // status
    output logic [PEND_BITS:0]    PEND_CNT,
    output logic                  ERR_UNEXP
);

    localparam int unsigned CNT_W = PEND_BITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rd_ok;
    logic                 req0;
    logic                 req1;
    logic                 grant0;
    logic                 grant1;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 spurious;
    logic                 pop_tag;
    logic [MAX_PEND-1:0]  tag_mem;
    logic [PEND_BITS-1:0] wr_ptr;
    logic [PEND_BITS-1:0] rd_ptr;

`ifdef TCAM_ARB_RR_EN
    logic                 last_grant;
`endif

    // A port is eligible if it writes, or reads while the tag FIFO still has room
    assign rd_ok    = (PEND_CNT < CNT_W'(MAX_PEND));
    assign req0     = SRCH_WRITE | (SRCH_READ & rd_ok);
    assign req1     = SET_WRITE  | (SET_READ  & rd_ok);
    assign push     = accept & M_READ;
    assign pop      = M_READDATAVALID & (PEND_CNT != '0);
    assign spurious = M_READDATAVALID & (PEND_CNT == '0);
    assign pop_tag  = tag_mem[rd_ptr];

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration and grant handshake; WAITREQUEST is combinational so the requester
    // sees acceptance in the same cycle the downstream takes the command
    always_comb begin
        state_nxt        = state;
        grant0           = 1'b0;
        grant1           = 1'b0;
        accept           = 1'b0;
        SRCH_WAITREQUEST = 1'b1;
        SET_WAITREQUEST  = 1'b1;
        case (state)
            IDLE: begin
`ifdef TCAM_ARB_RR_EN
                grant0 = req0 & (~req1 | last_grant);
`else
                grant0 = req0;
`endif
                grant1 = ~grant0 & req1;
                if (grant0) begin
                    state_nxt = G0;
                end else if (grant1) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                if (!M_WAITREQUEST) begin
                    accept           = 1'b1;
                    SRCH_WAITREQUEST = 1'b0;
                    state_nxt        = IDLE;
                end
            end
            G1: begin
                if (!M_WAITREQUEST) begin
                    accept          = 1'b1;
                    SET_WAITREQUEST = 1'b0;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TCAM_ARB_RR_EN
    // Remember the last winner so a tie goes to the other port
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    // Downstream command register: load on grant (write wins over read), drop strobes on accept
    always_ff @(posedge CLK) begin
        if (RESET) begin
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= '0;
            M_WRITEDATA <= '0;
        end else if (grant0) begin
            M_WRITE     <= SRCH_WRITE;
            M_READ      <= ~SRCH_WRITE;
            M_ADDRESS   <= SRCH_ADDRESS;
            M_WRITEDATA <= SRCH_WRITEDATA;
        end else if (grant1) begin
            M_WRITE     <= SET_WRITE;
            M_READ      <= ~SET_WRITE;
            M_ADDRESS   <= SET_ADDRESS;
            M_WRITEDATA <= SET_WRITEDATA;
        end else if (accept) begin
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
        end
    end

    // Tag FIFO of accepted reads and outstanding-read counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            PEND_CNT <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= (state == G1);
                wr_ptr          <= wr_ptr + PEND_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PEND_BITS'(1);
            end
            if (push && !pop) begin
                PEND_CNT <= PEND_CNT + CNT_W'(1);
            end else if (pop && !push) begin
                PEND_CNT <= PEND_CNT - CNT_W'(1);
            end
        end
    end

    // Route each return beat to the tagged port one cycle later; flag beats with no owner
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SRCH_READDATAVALID <= 1'b0;
            SET_READDATAVALID  <= 1'b0;
            SRCH_READDATA      <= '0;
            SET_READDATA       <= '0;
            ERR_UNEXP          <= 1'b0;
        end else begin
            SRCH_READDATAVALID <= pop & ~pop_tag;
            SET_READDATAVALID  <= pop & pop_tag;
            if (pop && !pop_tag) begin
                SRCH_READDATA <= M_READDATA;
            end
            if (pop && pop_tag) begin
                SET_READDATA <= M_READDATA;
            end
            if (spurious) begin
                ERR_UNEXP <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcam_sdram_arbiter.sv
// Scoreboard bench for tcam_sdram_arbiter: directed tests push expected downstream commands and
// per-port read beats into queues; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_tcam_sdram_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 180;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          srch_rd = 1'b0, srch_wr = 1'b0;
    logic [AW-1:0] srch_addr = '0;
    logic [DW-1:0] srch_wdata = '0;
    logic          srch_wait;
    logic [DW-1:0] srch_rdata;
    logic          srch_rdv;
    logic          set_rd = 1'b0, set_wr = 1'b0;
    logic [AW-1:0] set_addr = '0;
    logic [DW-1:0] set_wdata = '0;
    logic          set_wait;
    logic [DW-1:0] set_rdata;
    logic          set_rdv;
    logic          m_read, m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_wait = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_rdv = 1'b0;
    logic [3:0]    pend;
    logic          err;

    cmd_t          exp_cmd_q[$];
    logic [DW-1:0] exp_rd0_q[$];
    logic [DW-1:0] exp_rd1_q[$];
    ret_t          ret_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ret_lat = 1;
    bit ret_en = 1'b1;
    bit spur_req = 1'b0;
    int lo_cnt0 = 0;
    int lo_cnt1 = 0;

    tcam_sdram_arbiter dut (
        .CLK(clk), .RESET(rst),
        .SRCH_READ(srch_rd), .SRCH_WRITE(srch_wr), .SRCH_ADDRESS(srch_addr),
        .SRCH_WRITEDATA(srch_wdata), .SRCH_WAITREQUEST(srch_wait),
        .SRCH_READDATA(srch_rdata), .SRCH_READDATAVALID(srch_rdv),
        .SET_READ(set_rd), .SET_WRITE(set_wr), .SET_ADDRESS(set_addr),
        .SET_WRITEDATA(set_wdata), .SET_WAITREQUEST(set_wait),
        .SET_READDATA(set_rdata), .SET_READDATAVALID(set_rdv),
        .M_READ(m_read), .M_WRITE(m_write), .M_ADDRESS(m_addr), .M_WRITEDATA(m_wdata),
        .M_WAITREQUEST(m_wait), .M_READDATA(m_rdata), .M_READDATAVALID(m_rdv),
        .PEND_CNT(pend), .ERR_UNEXP(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {8'hC3, 153'd0, a};
    endfunction

    function automatic logic [DW-1:0] wr_word(input logic [AW-1:0] a);
        return {8'h5A, 153'd0, a};
    endfunction

    function automatic cmd_t mk_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.wr   = wr;
        c.addr = a;
        c.data = d;
        return c;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare downstream commands and per-port read beats against the scoreboard
    always @(negedge clk) begin
        cmd_t e;
        cmd_t a;
        if (!rst) begin
            if (!srch_wait) lo_cnt0++;
            if (!set_wait)  lo_cnt1++;
            if ((m_read || m_write) && !m_wait) begin
                if (m_read) ret_q.push_back('{cyc + ret_lat, mem_word(m_addr)});
                a = mk_cmd(m_write, m_addr, m_write ? m_wdata : '0);
                if (exp_cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got %0h expected none", a);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd", 256'(a), 256'(e));
                end
            end
            if (srch_rdv) begin
                if (exp_rd0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rdv0_unexpected: got %0h expected none", srch_rdata);
                end else begin
                    check("rdata0", 256'(srch_rdata), 256'(exp_rd0_q.pop_front()));
                end
            end
            if (set_rdv) begin
                if (exp_rd1_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rdv1_unexpected: got %0h expected none", set_rdata);
                end else begin
                    check("rdata1", 256'(set_rdata), 256'(exp_rd1_q.pop_front()));
                end
            end
        end
    end

    // SDRAM model: return read data in acceptance order after ret_lat cycles
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        m_rdv = 1'b0;
        if (spur_req) begin
            m_rdv    = 1'b1;
            m_rdata  = DW'(32'hDEAD);
            spur_req = 1'b0;
        end else if (ret_en && ret_q.size() != 0 && ret_q[0].due <= cyc) begin
            m_rdv   = 1'b1;
            m_rdata = ret_q[0].data;
            void'(ret_q.pop_front());
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        srch_rd = 1'b0; srch_wr = 1'b0; set_rd = 1'b0; set_wr = 1'b0;
        m_wait = 1'b0; ret_en = 1'b1; ret_lat = 1; spur_req = 1'b0;
        repeat (3) @(posedge clk);
        exp_cmd_q.delete(); exp_rd0_q.delete(); exp_rd1_q.delete(); ret_q.delete();
        #1 rst = 1'b0;
    endtask

    // Drive a command on port p and hold it until that port's WAITREQUEST is seen low
    task automatic port_cmd(input int p, input bit rd, input bit wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        if (p == 0) begin
            srch_rd = rd; srch_wr = wr; srch_addr = a; srch_wdata = d;
        end else begin
            set_rd = rd; set_wr = wr; set_addr = a; set_wdata = d;
        end
        do begin
            @(negedge clk);
            n++;
        end while ((p == 0 ? srch_wait : set_wait) && n < 300);
        if (p == 0 ? srch_wait : set_wait) begin
            checks++; errors++;
            $display("FAIL port%0d_timeout: got no accept for addr %0h expected accept", p, a);
        end
        @(posedge clk);
        #1;
        if (p == 0) begin srch_rd = 1'b0; srch_wr = 1'b0; end
        else        begin set_rd  = 1'b0; set_wr  = 1'b0; end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_cmd_q.size() + exp_rd0_q.size() + exp_rd1_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 256'(exp_cmd_q.size() + exp_rd0_q.size() + exp_rd1_q.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;

        // T1: reset values
        do_reset();
        @(negedge clk);
        check("rst_m_read",  256'(m_read),    256'(0));
        check("rst_m_write", 256'(m_write),   256'(0));
        check("rst_m_addr",  256'(m_addr),    256'(0));
        check("rst_m_wdata", 256'(m_wdata),   256'(0));
        check("rst_wait0",   256'(srch_wait), 256'(1));
        check("rst_wait1",   256'(set_wait),  256'(1));
        check("rst_rdv0",    256'(srch_rdv),  256'(0));
        check("rst_rdv1",    256'(set_rdv),   256'(0));
        check("rst_pend",    256'(pend),      256'(0));
        check("rst_err",     256'(err),       256'(0));

        // T2: SET write with downstream stalled 4 cycles
        do_reset();
        m_wait = 1'b1;
        exp_cmd_q.push_back(mk_cmd(1'b1, 19'h00010, wr_word(19'h00010)));
        c0 = lo_cnt0; c1 = lo_cnt1;
        fork
            port_cmd(1, 1'b0, 1'b1, 19'h00010, wr_word(19'h00010));
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!m_write && n < 20);
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    check("t2_stable", 256'({m_write, m_addr, m_wdata, set_wait}),
                          256'({1'b1, 19'h00010, wr_word(19'h00010), 1'b1}));
                end
                @(posedge clk);
                #1 m_wait = 1'b0;
            end
        join
        @(negedge clk);
        check("t2_m_write_drop", 256'(m_write), 256'(0));
        check("t2_wait1_lows", 256'(lo_cnt1 - c1), 256'(1));
        check("t2_wait0_lows", 256'(lo_cnt0 - c0), 256'(0));
        check("t2_pend", 256'(pend), 256'(0));
        repeat (4) @(negedge clk);
        drain("t2");

        // T3: both ports read back-to-back
        do_reset();
        ret_lat = 2;
`ifdef TCAM_ARB_RR_EN
        for (int i = 0; i < 8; i++) begin
            exp_cmd_q.push_back(mk_cmd(1'b0, AW'(32'h100 + i), '0));
            exp_cmd_q.push_back(mk_cmd(1'b0, AW'(32'h200 + i), '0));
        end
`else
        for (int i = 0; i < 8; i++) exp_cmd_q.push_back(mk_cmd(1'b0, AW'(32'h100 + i), '0));
        for (int i = 0; i < 8; i++) exp_cmd_q.push_back(mk_cmd(1'b0, AW'(32'h200 + i), '0));
`endif
        for (int i = 0; i < 8; i++) begin
            exp_rd0_q.push_back(mem_word(AW'(32'h100 + i)));
            exp_rd1_q.push_back(mem_word(AW'(32'h200 + i)));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) port_cmd(0, 1'b1, 1'b0, AW'(32'h100 + i), '0);
            end
            begin
                for (int j = 0; j < 8; j++) port_cmd(1, 1'b1, 1'b0, AW'(32'h200 + j), '0);
            end
        join
        drain("t3");

        // T4: read routing with 10-cycle return latency
        do_reset();
        ret_lat = 10;
        exp_cmd_q.push_back(mk_cmd(1'b0, 19'h00400, '0));
        exp_cmd_q.push_back(mk_cmd(1'b0, 19'h00401, '0));
        exp_cmd_q.push_back(mk_cmd(1'b0, 19'h00402, '0));
        exp_rd0_q.push_back(mem_word(19'h00400));
        exp_rd1_q.push_back(mem_word(19'h00401));
        exp_rd0_q.push_back(mem_word(19'h00402));
        port_cmd(0, 1'b1, 1'b0, 19'h00400, '0);
        @(negedge clk); check("t4_pend1", 256'(pend), 256'(1));
        port_cmd(1, 1'b1, 1'b0, 19'h00401, '0);
        @(negedge clk); check("t4_pend2", 256'(pend), 256'(2));
        port_cmd(0, 1'b1, 1'b0, 19'h00402, '0);
        @(negedge clk); check("t4_pend3", 256'(pend), 256'(3));
        drain("t4");
        @(negedge clk);
        check("t4_pend0", 256'(pend), 256'(0));
        check("t4_hold1", 256'(set_rdata),  256'(mem_word(19'h00401)));
        check("t4_hold0", 256'(srch_rdata), 256'(mem_word(19'h00402)));

        // T5: full tag FIFO gates the 9th read; a write still wins
        do_reset();
        ret_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_cmd_q.push_back(mk_cmd(1'b0, AW'(32'h500 + i), '0));
            exp_rd0_q.push_back(mem_word(AW'(32'h500 + i)));
        end
        for (int i = 0; i < 8; i++) port_cmd(0, 1'b1, 1'b0, AW'(32'h500 + i), '0);
        @(negedge clk);
        check("t5_pend_full", 256'(pend), 256'(8));
        exp_cmd_q.push_back(mk_cmd(1'b1, 19'h005F0, wr_word(19'h005F0)));
        exp_cmd_q.push_back(mk_cmd(1'b0, 19'h00508, '0));
        exp_rd0_q.push_back(mem_word(19'h00508));
        c0 = lo_cnt0;
        fork
            port_cmd(0, 1'b1, 1'b0, 19'h00508, '0);
            begin
                port_cmd(1, 1'b0, 1'b1, 19'h005F0, wr_word(19'h005F0));
                repeat (4) @(negedge clk);
                check("t5_srch_stalled", 256'(lo_cnt0 - c0), 256'(0));
                check("t5_pend_still", 256'(pend), 256'(8));
                check("t5_no_read", 256'(m_read), 256'(0));
                ret_en = 1'b1;
                @(negedge clk);
                check("t5_first_ret", 256'(m_rdv), 256'(1));
                @(negedge clk);
                check("t5_grant_cycle", 256'(m_read), 256'(0));
                @(negedge clk);
                check("t5_ninth_read", 256'({m_read, m_addr}), 256'({1'b1, 19'h00508}));
            end
        join
        drain("t5");

        // T6: return beat with nothing outstanding
        do_reset();
        @(negedge clk);
        spur_req = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_err_set", 256'(err), 256'(1));
        check("t6_no_rdv", 256'({srch_rdv, set_rdv}), 256'(0));
        repeat (5) @(negedge clk);
        check("t6_err_sticky", 256'(err), 256'(1));
        check("t6_pend", 256'(pend), 256'(0));

        // T7: READ and WRITE together on one port count as a write
        do_reset();
        exp_cmd_q.push_back(mk_cmd(1'b1, 19'h00600, wr_word(19'h00600)));
        port_cmd(0, 1'b1, 1'b1, 19'h00600, wr_word(19'h00600));
        @(negedge clk);
        check("t7_pend", 256'(pend), 256'(0));
        repeat (4) @(negedge clk);
        drain("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
